// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: i-cache request/response, decode-side handshake, EX redirect.
// master = the queue, slave = the i-cache/decode/EX side.
interface if_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            fetch_req;
  logic [XLEN-1:0] fetch_addr;
  logic            imem_busywait;
  logic [XLEN-1:0] imem_rdata;
  logic            hold;
  logic            branch_sel;
  logic [XLEN-1:0] b_pc;
  logic            valid;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] instr_out;
  logic [CW-1:0]   count;

  modport master (
    output fetch_req, fetch_addr, valid, pc_out, instr_out, count,
    input  imem_busywait, imem_rdata, hold, branch_sel, b_pc
  );

  modport slave (
    input  fetch_req, fetch_addr, valid, pc_out, instr_out, count,
    output imem_busywait, imem_rdata, hold, branch_sel, b_pc
  );
endinterface

// File: rtl/if_fetch_queue.sv
// DEPTH-entry prefetch FIFO of {pc, instr} between the i-cache and IF/ID.
// Optional statistics counters enabled by defining FETCH_QUEUE_STATS_EN.
module if_fetch_queue #(
  parameter int               XLEN    = 32,
  parameter int               DEPTH   = 4,
  parameter logic [XLEN-1:0]  BOOT_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  if_fetch_queue_if.master    bus
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]         stat_empty_cyc,
  output logic [31:0]         stat_flushes,
  output logic [31:0]         stat_discards
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {FETCH, DISCARD} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] fetch_pc, disc_addr;
  logic            miss_q;
  logic            in_flight, valid;
  logic            pop, push, fetch_req;
  logic [XLEN-1:0] fetch_addr;
  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] ins_mem [DEPTH];

  assign valid     = (count != '0);
  // A miss is still in flight if last cycle's request stalled and the cache is still busy.
  assign in_flight = miss_q & bus.imem_busywait;

  always_comb begin
    state_nxt  = state;
    fetch_req  = 1'b0;
    fetch_addr = fetch_pc;
    pop        = 1'b0;
    push       = 1'b0;
    case (state)
      FETCH: begin
        pop       = valid & ~bus.hold & ~bus.branch_sel;
        fetch_req = ((count < CW'(DEPTH)) | pop) & ~bus.branch_sel & reset;
        push      = fetch_req & ~bus.imem_busywait;
        if (bus.branch_sel && in_flight) state_nxt = DISCARD;
      end
      DISCARD: begin
        // Keep the abandoned request alive until the cache answers, then drop it.
        fetch_req  = 1'b1;
        fetch_addr = disc_addr;
        if (!bus.imem_busywait) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fetch_pc  <= BOOT_PC;
      disc_addr <= BOOT_PC;
      miss_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      miss_q <= fetch_req & bus.imem_busywait;
      if (bus.branch_sel) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        fetch_pc <= bus.b_pc;
        if (state == FETCH) disc_addr <= fetch_pc;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + 1'b1;
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= fetch_pc;
      ins_mem[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.fetch_req  = fetch_req;
  assign bus.fetch_addr = fetch_addr;
  assign bus.valid      = valid;
  assign bus.count      = count;
  assign bus.pc_out     = valid ? pc_mem[rd_ptr]  : '0;
  assign bus.instr_out  = valid ? ins_mem[rd_ptr] : '0;

`ifdef FETCH_QUEUE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_empty_cyc <= '0;
      stat_flushes   <= '0;
      stat_discards  <= '0;
    end else begin
      if (!valid && state == FETCH && stat_empty_cyc != '1) stat_empty_cyc <= stat_empty_cyc + 1'b1;
      if (bus.branch_sel && stat_flushes != '1)             stat_flushes   <= stat_flushes + 1'b1;
      if (state == FETCH && state_nxt == DISCARD && stat_discards != '1)
        stat_discards <= stat_discards + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: vector table plus redirect/miss/reset sequences.
module tb_if_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_empty_cyc, stat_flushes, stat_discards;
`endif

  if_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .BOOT_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stat_empty_cyc (stat_empty_cyc),
    .stat_flushes   (stat_flushes),
    .stat_discards  (stat_discards)
`endif
  );

  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  always_comb bus.imem_rdata = img(bus.fetch_addr);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                         input logic v, input logic [31:0] pc, input logic [31:0] cnt);
    chk({tag, ".req"},   32'(bus.fetch_req), 32'(req));
    chk({tag, ".addr"},  bus.fetch_addr, addr);
    chk({tag, ".valid"}, 32'(bus.valid), 32'(v));
    chk({tag, ".pc"},    bus.pc_out, v ? pc : 32'h0);
    chk({tag, ".instr"}, bus.instr_out, v ? img(pc) : 32'h0);
    chk({tag, ".count"}, 32'(bus.count), cnt);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.hold = 1'b0; bus.branch_sel = 1'b0; bus.b_pc = '0; bus.imem_busywait = 1'b0;
    #1;
    chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  typedef struct {
    logic        hold, bsel, busy;
    logic [31:0] bpc;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic hold, input logic bsel, input logic [31:0] bpc,
                              input logic busy, input logic req, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc, input logic [31:0] cnt);
    vec_t r;
    r.hold = hold; r.bsel = bsel; r.bpc = bpc; r.busy = busy;
    r.req = req; r.addr = addr; r.v = v; r.pc = pc; r.cnt = cnt;
    return r;
  endfunction

  vec_t tv[18];
  logic found;

  initial begin
    bus.hold = 1'b0; bus.branch_sel = 1'b0; bus.b_pc = '0; bus.imem_busywait = 1'b0;

    //           hold bsel bpc      busy req addr     v  pc       cnt
    tv[0]  = mk(0, 0, 32'h0,   0, 1, 32'h00,  0, 32'h0,   0);
    tv[1]  = mk(0, 0, 32'h0,   0, 1, 32'h04,  1, 32'h00,  1);
    tv[2]  = mk(0, 0, 32'h0,   0, 1, 32'h08,  1, 32'h04,  1);
    tv[3]  = mk(1, 0, 32'h0,   0, 1, 32'h0C,  1, 32'h08,  1);
    tv[4]  = mk(1, 0, 32'h0,   0, 1, 32'h10,  1, 32'h08,  2);
    tv[5]  = mk(1, 0, 32'h0,   0, 1, 32'h14,  1, 32'h08,  3);
    tv[6]  = mk(1, 0, 32'h0,   0, 0, 32'h18,  1, 32'h08,  4);
    tv[7]  = mk(1, 0, 32'h0,   0, 0, 32'h18,  1, 32'h08,  4);
    tv[8]  = mk(0, 0, 32'h0,   0, 1, 32'h18,  1, 32'h08,  4);
    tv[9]  = mk(0, 0, 32'h0,   0, 1, 32'h1C,  1, 32'h0C,  4);
    tv[10] = mk(0, 0, 32'h0,   0, 1, 32'h20,  1, 32'h10,  4);
    tv[11] = mk(0, 1, 32'h100, 0, 0, 32'h24,  1, 32'h14,  4);
    tv[12] = mk(0, 0, 32'h0,   0, 1, 32'h100, 0, 32'h0,   0);
    tv[13] = mk(0, 0, 32'h0,   0, 1, 32'h104, 1, 32'h100, 1);
    tv[14] = mk(0, 0, 32'h0,   1, 1, 32'h108, 1, 32'h104, 1);
    tv[15] = mk(0, 0, 32'h0,   1, 1, 32'h108, 0, 32'h0,   0);
    tv[16] = mk(0, 0, 32'h0,   0, 1, 32'h108, 0, 32'h0,   0);
    tv[17] = mk(0, 0, 32'h0,   0, 1, 32'h10C, 1, 32'h108, 1);

    apply_reset();
    for (int i = 0; i < 18; i++) begin
      bus.hold = tv[i].hold; bus.branch_sel = tv[i].bsel;
      bus.b_pc = tv[i].bpc;  bus.imem_busywait = tv[i].busy;
      #1;
      chk_all($sformatf("vec%0d", i), tv[i].req, tv[i].addr, tv[i].v, tv[i].pc, tv[i].cnt);
      step();
    end

    // Redirect to 0x200 during a 5-cycle miss at 0x40.
    apply_reset();
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.fetch_addr == 32'h40) begin found = 1'b1; break; end
      step();
    end
    chk("miss.reach40", 32'(found), 32'd1);
    chk_all("miss.m0", 1'b1, 32'h40, 1'b1, 32'h3C, 32'd1);
    bus.imem_busywait = 1'b1;
    step();
    chk_all("miss.m1", 1'b1, 32'h40, 1'b0, 32'h0, 32'd0);
    step();
    bus.branch_sel = 1'b1; bus.b_pc = 32'h200;
    #1;
    chk("miss.m2.req",  32'(bus.fetch_req), 32'd0);
    chk("miss.m2.addr", bus.fetch_addr, 32'h40);
    step();
    bus.branch_sel = 1'b0; bus.b_pc = '0;
    for (int k = 3; k < 5; k++) begin
      #1;
      chk_all($sformatf("miss.m%0d", k), 1'b1, 32'h40, 1'b0, 32'h0, 32'd0);
      step();
    end
    bus.imem_busywait = 1'b0;
    #1;
    chk_all("miss.m5", 1'b1, 32'h40, 1'b0, 32'h0, 32'd0);
    step();
    chk_all("miss.m6", 1'b1, 32'h200, 1'b0, 32'h0, 32'd0);
    step();
    chk("miss.m7.pc",    bus.pc_out, 32'h200);
    chk("miss.m7.instr", bus.instr_out, img(32'h200));

    // Redirect to 0x100 with three entries queued and no miss pending.
    apply_reset();
    bus.hold = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.count == 3) begin found = 1'b1; break; end
      step();
    end
    chk("br.reach3", 32'(found), 32'd1);
    bus.branch_sel = 1'b1; bus.b_pc = 32'h100;
    #1;
    chk("br.req", 32'(bus.fetch_req), 32'd0);
    chk("br.pc",  bus.pc_out, 32'h0);
    step();
    bus.branch_sel = 1'b0; bus.hold = 1'b0;
    #1;
    chk_all("br.next", 1'b1, 32'h100, 1'b0, 32'h0, 32'd0);
    step();
    chk_all("br.after", 1'b1, 32'h104, 1'b1, 32'h100, 32'd1);

    // Async reset in the middle of a miss with two entries queued.
    apply_reset();
    bus.hold = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.count == 2) begin found = 1'b1; break; end
      step();
    end
    chk("rst.reach2", 32'(found), 32'd1);
    bus.imem_busywait = 1'b1;
    step();
    step();
    chk_all("rst.pre", 1'b1, 32'h08, 1'b1, 32'h0, 32'd2);
    #2;
    reset = 1'b0;
    #1;
    chk_all("rst.mid", 1'b0, 32'h0, 1'b0, 32'h0, 32'd0);
    @(negedge clk);
    reset = 1'b1; bus.imem_busywait = 1'b0; bus.hold = 1'b0;
    #1;
    chk_all("rst.rel", 1'b1, 32'h0, 1'b0, 32'h0, 32'd0);
    step();
    chk_all("rst.first", 1'b1, 32'h4, 1'b1, 32'h0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
